// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with multi-character frame assembly.
// Receives DATA_BITS data bits (LSB first), optional odd/even parity and 1-2 stop
// bits, then collects BYTES_PER_FRAME good characters into one frame.
// Parity/framing errors pulse a flag and restart frame assembly from slot 0.
// Optional macro UART_RX_TIMEOUT_EN adds an inter-character gap timeout that
// discards a partial frame after TIMEOUT_BITS idle bit periods.
module uart_rx_frame #(
  parameter int CLOCKS_POR_BIT  = 5209,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int BYTES_PER_FRAME = 2,
  parameter int TIMEOUT_BITS    = 20
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 bitSerialAtual,
  output logic [DATA_BITS-1:0]                 byte_data,
  output logic                                 byte_valid,
  output logic [DATA_BITS*BYTES_PER_FRAME-1:0] frame_data,
  output logic                                 frame_valid,
  output logic                                 parity_error,
  output logic                                 framing_error,
  output logic                                 busy
);

  localparam int CNT_W   = $clog2(CLOCKS_POR_BIT);
  localparam int IDX_W   = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam int FRAME_W = DATA_BITS * BYTES_PER_FRAME;
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLOCKS_POR_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_POR_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_FRAME - 1);

  // Reject unsupported configurations at elaboration time.
  if (CLOCKS_POR_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      BYTES_PER_FRAME < 1 || BYTES_PER_FRAME > 8 || TIMEOUT_BITS < 1) begin : g_bad_params
    $error("uart_rx_frame: unsupported parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BREAK} state_t;

  state_t               state, state_next;
  logic                 sync1, line;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err;
  logic [IDX_W-1:0]     index;
  logic [FRAME_W-1:0]   assembly, assembled;
  logic                 mid_start, bit_tick, timeout_hit;

  assign mid_start = (cnt == CNT_HALF);
  assign bit_tick  = (cnt == CNT_LAST);

  // Two-flop synchroniser; the line idles high so reset loads ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= bitSerialAtual;
      line  <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; every decision uses the synchronised line.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!line) state_next = START;
      START:   if (mid_start) state_next = line ? IDLE : DATA;
      DATA:    if (bit_tick && bit_idx == DATA_LAST)
                 state_next = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:  if (bit_tick) state_next = STOP;
      STOP:    if (bit_tick && bit_idx == STOP_LAST) state_next = DONE;
      DONE:    state_next = frm_err ? BREAK : IDLE;
      BREAK:   if (line) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Assembly buffer with the current character dropped into its slot, so the
  // final character and the frame output update together.
  always_comb begin
    assembled = assembly;
    for (int k = 0; k < BYTES_PER_FRAME; k++) begin
      if (index == IDX_W'(k)) assembled[k*DATA_BITS +: DATA_BITS] = shreg;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int GAP_LIMIT = TIMEOUT_BITS * CLOCKS_POR_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  logic [GAP_W-1:0] gap_cnt;

  // Idle-gap counter; only runs while a partial frame waits in IDLE.
  always_ff @(posedge clock) begin
    if (reset || state != IDLE || index == '0 || !line) gap_cnt <= '0;
    else                                                gap_cnt <= gap_cnt + 1'b1;
  end

  assign timeout_hit = (state == IDLE) && (index != '0) && line &&
                       (gap_cnt == GAP_W'(GAP_LIMIT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Bit timing, shifting, error latching, frame assembly and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      index         <= '0;
      assembly      <= '0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      frame_data    <= '0;
      frame_valid   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      byte_valid    <= 1'b0;
      frame_valid   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= (state_next != IDLE);
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
          if (timeout_hit) index <= '0;
        end
        START: cnt <= mid_start ? '0 : cnt + 1'b1;
        DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            shreg   <= {line, shreg[DATA_BITS-1:1]};
            bit_idx <= (bit_idx == DATA_LAST) ? 4'd0 : bit_idx + 4'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_err <= (((^shreg) ^ line) == (PARITY_MODE == 2));
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt     <= '0;
            bit_idx <= (bit_idx == STOP_LAST) ? 4'd0 : bit_idx + 4'd1;
            if (!line) frm_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
          if (frm_err) begin
            framing_error <= 1'b1;
            index         <= '0;
          end else if (par_err) begin
            parity_error <= 1'b1;
            index        <= '0;
          end else begin
            byte_data  <= shreg;
            byte_valid <= 1'b1;
            assembly   <= assembled;
            if (index == IDX_LAST) begin
              frame_data  <= assembled;
              frame_valid <= 1'b1;
              index       <= '0;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: self-checking bench for uart_rx_frame.
// Two instances share clock and reset: dut_a is 8N1, dut_b uses even parity.
// A queue-based reference model tracks expected characters and frames.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic clock = 1'b0;
  logic reset;
  logic rx_a, rx_b;

  logic [7:0]  a_byte_data, b_byte_data;
  logic [15:0] a_frame_data, b_frame_data;
  logic a_byte_valid, a_frame_valid, a_parity_error, a_framing_error, a_busy;
  logic b_byte_valid, b_frame_valid, b_parity_error, b_framing_error, b_busy;

  int checks = 0;
  int failures = 0;

  // Observed pulse history, element 0 = dut_a, element 1 = dut_b.
  int obs_nb[2]    = '{0, 0};
  int obs_nf[2]    = '{0, 0};
  int obs_perr[2]  = '{0, 0};
  int obs_ferr[2]  = '{0, 0};
  int obs_split[2] = '{0, 0};
  logic [7:0]  obs_byte[2]  = '{8'h00, 8'h00};
  logic [15:0] obs_frame[2] = '{16'h0000, 16'h0000};

  // Reference model state.
  int exp_nb[2]   = '{0, 0};
  int exp_nf[2]   = '{0, 0};
  int exp_perr[2] = '{0, 0};
  int exp_ferr[2] = '{0, 0};
  logic [7:0]  exp_byte[2]  = '{8'h00, 8'h00};
  logic [15:0] exp_frame[2] = '{16'h0000, 16'h0000};
  logic [7:0]  pend_a[$];
  logic [7:0]  pend_b[$];

  always #5 clock = ~clock;

  uart_rx_frame #(.CLOCKS_POR_BIT(CPB)) dut_a (
    .clock(clock), .reset(reset), .bitSerialAtual(rx_a),
    .byte_data(a_byte_data), .byte_valid(a_byte_valid),
    .frame_data(a_frame_data), .frame_valid(a_frame_valid),
    .parity_error(a_parity_error), .framing_error(a_framing_error), .busy(a_busy)
  );

  uart_rx_frame #(.CLOCKS_POR_BIT(CPB), .PARITY_MODE(2)) dut_b (
    .clock(clock), .reset(reset), .bitSerialAtual(rx_b),
    .byte_data(b_byte_data), .byte_valid(b_byte_valid),
    .frame_data(b_frame_data), .frame_valid(b_frame_valid),
    .parity_error(b_parity_error), .framing_error(b_framing_error), .busy(b_busy)
  );

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (a_byte_valid) begin obs_nb[0]++; obs_byte[0] = a_byte_data; end
    if (a_frame_valid) begin obs_nf[0]++; obs_frame[0] = a_frame_data; end
    if (a_frame_valid && !a_byte_valid) obs_split[0]++;
    if (a_parity_error) obs_perr[0]++;
    if (a_framing_error) obs_ferr[0]++;
    if (b_byte_valid) begin obs_nb[1]++; obs_byte[1] = b_byte_data; end
    if (b_frame_valid) begin obs_nf[1]++; obs_frame[1] = b_frame_data; end
    if (b_frame_valid && !b_byte_valid) obs_split[1]++;
    if (b_parity_error) obs_perr[1]++;
    if (b_framing_error) obs_ferr[1]++;
  end

  // Model: a good character is reported and joins the pending frame.
  function automatic void model_good(input int d, input logic [7:0] v);
    exp_nb[d]++;
    exp_byte[d] = v;
    if (d == 0) begin
      pend_a.push_back(v);
      if (pend_a.size() == 2) begin
        exp_frame[0] = {pend_a[1], pend_a[0]};
        exp_nf[0]++;
        pend_a.delete();
      end
    end else begin
      pend_b.push_back(v);
      if (pend_b.size() == 2) begin
        exp_frame[1] = {pend_b[1], pend_b[0]};
        exp_nf[1]++;
        pend_b.delete();
      end
    end
  endfunction

  // Model: the partial frame is thrown away.
  function automatic void model_drop(input int d);
    if (d == 0) pend_a.delete();
    else        pend_b.delete();
  endfunction

  // Model: an erroneous character produces its flag and discards the frame.
  function automatic void model_err(input int d, input bit is_framing);
    if (is_framing) exp_ferr[d]++;
    else            exp_perr[d]++;
    model_drop(d);
  endfunction

  task automatic drive_bit(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_char(input int d, input logic [7:0] v, input bit with_par,
                           input logic par_bit, input logic stop_bit, input int idle_bits);
    drive_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, v[i]);
    if (with_par) drive_bit(d, par_bit);
    drive_bit(d, stop_bit);
    for (int i = 0; i < idle_bits; i++) drive_bit(d, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({a_byte_data, a_byte_valid, a_frame_data, a_frame_valid, a_parity_error,
         a_framing_error, a_busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_a: got %h required 0", {a_byte_data, a_frame_data,
               a_byte_valid, a_frame_valid, a_parity_error, a_framing_error, a_busy});
    end
    checks++;
    if ({b_byte_data, b_byte_valid, b_frame_data, b_frame_valid, b_parity_error,
         b_framing_error, b_busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_b: got %h required 0", {b_byte_data, b_frame_data,
               b_byte_valid, b_frame_valid, b_parity_error, b_framing_error, b_busy});
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_basic_frame();
    logic [7:0] v;
    send_char(0, 8'hA5, 1'b0, 1'b0, 1'b1, 0);
    model_good(0, 8'hA5);
    checks++;
    if (obs_byte[0] !== 8'hA5 || obs_nb[0] !== exp_nb[0]) begin
      failures++;
      $display("[TB] FAIL basic_first_byte: got %h/%0d required a5/%0d", obs_byte[0], obs_nb[0], exp_nb[0]);
    end
    send_char(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
    model_good(0, 8'h3C);
    checks++;
    if (obs_byte[0] !== 8'h3C || obs_nb[0] !== exp_nb[0]) begin
      failures++;
      $display("[TB] FAIL basic_second_byte: got %h/%0d required 3c/%0d", obs_byte[0], obs_nb[0], exp_nb[0]);
    end
    checks++;
    if (obs_frame[0] !== 16'h3CA5 || obs_nf[0] !== exp_nf[0]) begin
      failures++;
      $display("[TB] FAIL basic_frame: got %h/%0d required 3ca5/%0d", obs_frame[0], obs_nf[0], exp_nf[0]);
    end
    checks++;
    if (obs_split[0] !== 0 || a_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_coincide_idle: split %0d busy %b required 0/0", obs_split[0], a_busy);
    end
    for (int n = 0; n < 6; n++) begin
      v = 8'($urandom);
      send_char(0, v, 1'b0, 1'b0, 1'b1, $urandom_range(0, 2));
      model_good(0, v);
      checks++;
      if (obs_byte[0] !== exp_byte[0] || obs_nb[0] !== exp_nb[0] ||
          obs_frame[0] !== exp_frame[0] || obs_nf[0] !== exp_nf[0]) begin
        failures++;
        $display("[TB] FAIL random_8n1: got byte %h/%0d frame %h/%0d required %h/%0d %h/%0d",
                 obs_byte[0], obs_nb[0], obs_frame[0], obs_nf[0],
                 exp_byte[0], exp_nb[0], exp_frame[0], exp_nf[0]);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] v;
    bit bad;
    send_char(1, 8'h07, 1'b1, 1'b1, 1'b1, 1);
    model_good(1, 8'h07);
    checks++;
    if (obs_byte[1] !== 8'h07 || obs_nb[1] !== exp_nb[1] || obs_perr[1] !== exp_perr[1]) begin
      failures++;
      $display("[TB] FAIL parity_good: got %h/%0d perr %0d required 07/%0d perr %0d",
               obs_byte[1], obs_nb[1], obs_perr[1], exp_nb[1], exp_perr[1]);
    end
    send_char(1, 8'h07, 1'b1, 1'b0, 1'b1, 1);
    model_err(1, 1'b0);
    checks++;
    if (obs_perr[1] !== exp_perr[1] || obs_nb[1] !== exp_nb[1] || obs_ferr[1] !== 0) begin
      failures++;
      $display("[TB] FAIL parity_bad: got perr %0d nb %0d ferr %0d required %0d/%0d/0",
               obs_perr[1], obs_nb[1], obs_ferr[1], exp_perr[1], exp_nb[1]);
    end
    for (int n = 0; n < 8; n++) begin
      v = 8'($urandom);
      bad = (n >= 2) && ($urandom_range(0, 3) == 0);
      send_char(1, v, 1'b1, (^v) ^ bad, 1'b1, $urandom_range(0, 1));
      if (bad) model_err(1, 1'b0);
      else     model_good(1, v);
      checks++;
      if (obs_byte[1] !== exp_byte[1] || obs_nb[1] !== exp_nb[1] || obs_perr[1] !== exp_perr[1] ||
          obs_frame[1] !== exp_frame[1] || obs_nf[1] !== exp_nf[1]) begin
        failures++;
        $display("[TB] FAIL parity_random: got %h/%0d perr %0d frame %h/%0d required %h/%0d perr %0d frame %h/%0d",
                 obs_byte[1], obs_nb[1], obs_perr[1], obs_frame[1], obs_nf[1],
                 exp_byte[1], exp_nb[1], exp_perr[1], exp_frame[1], exp_nf[1]);
      end
    end
  endtask

  task automatic test_framing();
    send_char(0, 8'h55, 1'b0, 1'b0, 1'b0, 0);
    repeat (29) drive_bit(0, 1'b0);
    model_err(0, 1'b1);
    checks++;
    if (obs_ferr[0] !== exp_ferr[0] || obs_nb[0] !== exp_nb[0] || obs_perr[0] !== 0) begin
      failures++;
      $display("[TB] FAIL framing_single: got ferr %0d nb %0d perr %0d required %0d/%0d/0",
               obs_ferr[0], obs_nb[0], obs_perr[0], exp_ferr[0], exp_nb[0]);
    end
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL framing_busy_held: got %b required 1", a_busy);
    end
    rx_a = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL framing_busy_release: got %b required 0", a_busy);
    end
    send_char(0, 8'h12, 1'b0, 1'b0, 1'b1, 0);
    model_good(0, 8'h12);
    send_char(0, 8'h34, 1'b0, 1'b0, 1'b1, 1);
    model_good(0, 8'h34);
    checks++;
    if (obs_frame[0] !== 16'h3412 || obs_nf[0] !== exp_nf[0] || obs_frame[0] !== exp_frame[0]) begin
      failures++;
      $display("[TB] FAIL framing_recover: got %h/%0d required 3412/%0d", obs_frame[0], obs_nf[0], exp_nf[0]);
    end
  endtask

  task automatic test_glitch();
    rx_a = 1'b0;
    repeat (5) @(negedge clock);
    rx_a = 1'b1;
    repeat (6) @(negedge clock);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch_idle: busy got %b required 0", a_busy);
    end
    repeat (2 * CPB) @(negedge clock);
    checks++;
    if (obs_nb[0] !== exp_nb[0] || obs_perr[0] !== exp_perr[0] || obs_ferr[0] !== exp_ferr[0]) begin
      failures++;
      $display("[TB] FAIL glitch_no_pulse: got %0d/%0d/%0d required %0d/%0d/%0d",
               obs_nb[0], obs_perr[0], obs_ferr[0], exp_nb[0], exp_perr[0], exp_ferr[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int n = 0; n < 8; n++) begin
      v = 8'($urandom);
      send_char(0, v, 1'b0, 1'b0, 1'b1, (n == 7) ? 1 : 0);
      model_good(0, v);
      checks++;
      if (obs_byte[0] !== exp_byte[0] || obs_nb[0] !== exp_nb[0] ||
          obs_frame[0] !== exp_frame[0] || obs_nf[0] !== exp_nf[0]) begin
        failures++;
        $display("[TB] FAIL back_to_back: got byte %h/%0d frame %h/%0d required %h/%0d %h/%0d",
                 obs_byte[0], obs_nb[0], obs_frame[0], obs_nf[0],
                 exp_byte[0], exp_nb[0], exp_frame[0], exp_nf[0]);
      end
    end
    checks++;
    if (obs_split[0] !== 0 || obs_split[1] !== 0) begin
      failures++;
      $display("[TB] FAIL frame_without_byte: got %0d/%0d required 0/0", obs_split[0], obs_split[1]);
    end
  endtask

  task automatic test_reset_mid();
    send_char(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1);
    model_good(0, 8'h5A);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({a_byte_data, a_byte_valid, a_frame_data, a_frame_valid, a_parity_error,
         a_framing_error, a_busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got %h required 0", {a_byte_data, a_frame_data,
               a_byte_valid, a_frame_valid, a_parity_error, a_framing_error, a_busy});
    end
    reset = 1'b0;
    rx_a = 1'b1;
    model_drop(0);
    model_drop(1);
    repeat (CPB) @(negedge clock);
    send_char(0, 8'h01, 1'b0, 1'b0, 1'b1, 0);
    model_good(0, 8'h01);
    send_char(0, 8'h02, 1'b0, 1'b0, 1'b1, 1);
    model_good(0, 8'h02);
    checks++;
    if (obs_frame[0] !== 16'h0201 || obs_nf[0] !== exp_nf[0] || obs_nb[0] !== exp_nb[0]) begin
      failures++;
      $display("[TB] FAIL reset_mid_frame: got %h/%0d/%0d required 0201/%0d/%0d",
               obs_frame[0], obs_nf[0], obs_nb[0], exp_nf[0], exp_nb[0]);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] want;
    send_char(0, 8'hAA, 1'b0, 1'b0, 1'b1, 25);
    model_good(0, 8'hAA);
`ifdef UART_RX_TIMEOUT_EN
    model_drop(0);
    want = 16'h2211;
`else
    want = 16'h11AA;
`endif
    send_char(0, 8'h11, 1'b0, 1'b0, 1'b1, 0);
    model_good(0, 8'h11);
    send_char(0, 8'h22, 1'b0, 1'b0, 1'b1, 1);
    model_good(0, 8'h22);
    checks++;
    if (obs_frame[0] !== want || obs_frame[0] !== exp_frame[0] || obs_nf[0] !== exp_nf[0]) begin
      failures++;
      $display("[TB] FAIL timeout_frame: got %h/%0d required %h/%0d", obs_frame[0], obs_nf[0], want, exp_nf[0]);
    end
    checks++;
    if (obs_byte[0] !== 8'h22 || obs_nb[0] !== exp_nb[0]) begin
      failures++;
      $display("[TB] FAIL timeout_bytes: got %h/%0d required 22/%0d", obs_byte[0], obs_nb[0], exp_nb[0]);
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    rx_a = 1'b1;
    rx_b = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_basic_frame();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
